// File: rtl/ship_motion_ctl_pkg.sv
// Shared definitions for the player-ship motion controller: FSM state
// encodings, default play-field geometry and the x clamp helper.
package ship_motion_ctl_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_MOVE_L  = 3'd1;
   localparam logic [2:0] ST_MOVE_R  = 3'd2;
   localparam logic [2:0] ST_DEAD    = 3'd3;
   localparam logic [2:0] ST_RESPAWN = 3'd4;

   localparam int DEF_X_MIN      = 80;
   localparam int DEF_X_EDGE     = 944;
   localparam int DEF_SHIP_WIDTH = 83;

   localparam int XPOS_W  = 11;
   localparam int SPEED_W = 3;

   // Limit a signed intermediate x to [lo, hi] and return it as a screen coordinate.
   function automatic logic [XPOS_W-1:0] clamp_x(input logic signed [XPOS_W:0] v,
                                                 input logic signed [XPOS_W:0] lo,
                                                 input logic signed [XPOS_W:0] hi);
      logic signed [XPOS_W:0] r;
      r = v;
      if (v < lo) r = lo;
      else if (v > hi) r = hi;
      return r[XPOS_W-1:0];
   endfunction

endpackage

// File: rtl/ship_motion_ctl_tick_gen.sv
// Game tick generator: free-running prescaler that pulses o_tick for one
// pclk every TICK_DIV enabled cycles. Holding i_en low stalls the count.
module ship_motion_ctl_tick_gen #(
   parameter int TICK_DIV = 30000
) (
   input  logic pclk,
   input  logic rst,
   input  logic i_en,
   output logic o_tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Prescaler count 0..TICK_DIV-1, advancing only while enabled.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == CNT_LAST) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ship_motion_ctl.sv
// Player-ship horizontal motion controller: turns left/right key levels into
// a ramped, clamped x position, and runs the death / respawn blink sequence.
module ship_motion_ctl
   import ship_motion_ctl_pkg::*;
#(
   parameter int RESET_X_POS   = 472,
   parameter int SHIP_WIDTH    = DEF_SHIP_WIDTH,
   parameter int X_MIN         = DEF_X_MIN,
   parameter int X_EDGE        = DEF_X_EDGE,
   parameter int TICK_DIV      = 30000,
   parameter int MAX_SPEED     = 4,
   parameter int ACCEL_TICKS   = 8,
   parameter int RESPAWN_TICKS = 120,
   parameter int BLINK_TICKS   = 8
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               dead_s,
   input  logic               left,
   input  logic               right,
   input  logic               freeze,
   output logic [XPOS_W-1:0]  xpos_out,
   output logic [SPEED_W-1:0] speed_out,
   output logic               ship_visible,
   output logic               respawn_busy
);

   localparam int X_MAX = X_EDGE - SHIP_WIDTH;
   localparam int ACC_W = (ACCEL_TICKS   > 1) ? $clog2(ACCEL_TICKS)   : 1;
   localparam int RSP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
   localparam int BLK_W = (BLINK_TICKS   > 1) ? $clog2(BLINK_TICKS)   : 1;

   localparam logic [XPOS_W-1:0]        X_RST    = XPOS_W'(RESET_X_POS);
   localparam logic signed [XPOS_W:0]   XMIN_S   = (XPOS_W+1)'(X_MIN);
   localparam logic signed [XPOS_W:0]   XMAX_S   = (XPOS_W+1)'(X_MAX);
   localparam logic [SPEED_W-1:0]       SPD_MAX  = SPEED_W'(MAX_SPEED);
   localparam logic [ACC_W-1:0]         ACC_LAST = ACC_W'(ACCEL_TICKS - 1);
   localparam logic [RSP_W-1:0]         RSP_LAST = RSP_W'(RESPAWN_TICKS - 1);
   localparam logic [BLK_W-1:0]         BLK_LAST = BLK_W'(BLINK_TICKS - 1);

   logic [2:0]         r_state;
   logic [XPOS_W-1:0]  r_x;
   logic [SPEED_W-1:0] r_speed;
   logic [ACC_W-1:0]   r_acc;
   logic [RSP_W-1:0]   r_rsp;
   logic [BLK_W-1:0]   r_blk;
   logic               r_vis;

   logic                    w_tick;
   logic                    w_moving;
   logic                    w_stop;
   logic signed [XPOS_W:0]  w_x_s;
   logic signed [XPOS_W:0]  w_spd_s;
   logic [XPOS_W-1:0]       w_x_next;
   logic [SPEED_W-1:0]      w_spd_inc;

   ship_motion_ctl_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .pclk   (pclk),
      .rst    (rst),
      .i_en   (!freeze),
      .o_tick (w_tick)
   );

   // Candidate position/speed for the next motion tick and the stop condition of the active direction.
   always_comb begin
      w_moving  = (r_state == ST_MOVE_L) || (r_state == ST_MOVE_R);
      w_x_s     = $signed({1'b0, r_x});
      w_spd_s   = $signed({{(XPOS_W+1-SPEED_W){1'b0}}, r_speed});
      w_x_next  = r_x;
      w_stop    = 1'b0;
      if (r_state == ST_MOVE_L) begin
         w_x_next = clamp_x(w_x_s - w_spd_s, XMIN_S, XMAX_S);
         w_stop   = !left || right;
      end else if (r_state == ST_MOVE_R) begin
         w_x_next = clamp_x(w_x_s + w_spd_s, XMIN_S, XMAX_S);
         w_stop   = !right || left;
      end
      w_spd_inc = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 1'b1;
   end

   // Motion / respawn state machine; freeze holds everything, reset overrides freeze.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_x     <= X_RST;
         r_speed <= '0;
         r_acc   <= '0;
         r_rsp   <= '0;
         r_blk   <= '0;
         r_vis   <= 1'b1;
      end else if (!freeze) begin
         if ((r_state == ST_IDLE || w_moving) && dead_s) begin
            r_state <= ST_DEAD;
            r_x     <= '0;
            r_speed <= '0;
            r_acc   <= '0;
            r_vis   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (left && !right) begin
                     r_state <= ST_MOVE_L;
                     r_speed <= SPEED_W'(1);
                     r_acc   <= '0;
                  end else if (right && !left) begin
                     r_state <= ST_MOVE_R;
                     r_speed <= SPEED_W'(1);
                     r_acc   <= '0;
                  end
               end
               ST_MOVE_L, ST_MOVE_R: begin
                  // A tick in the last cycle of a move still applies; leaving then zeroes speed.
                  if (w_tick) begin
                     r_x <= w_x_next;
                     if (r_acc == ACC_LAST) begin
                        r_acc   <= '0;
                        r_speed <= w_spd_inc;
                     end else begin
                        r_acc <= r_acc + 1'b1;
                     end
                  end
                  if (w_stop) begin
                     r_state <= ST_IDLE;
                     r_speed <= '0;
                     r_acc   <= '0;
                  end
               end
               ST_DEAD: begin
                  if (w_tick) begin
                     r_state <= ST_RESPAWN;
                     r_x     <= X_RST;
                     r_rsp   <= '0;
                     r_blk   <= '0;
                     r_vis   <= 1'b0;
                  end
               end
               ST_RESPAWN: begin
                  if (w_tick) begin
                     if (r_rsp == RSP_LAST) begin
                        r_state <= ST_IDLE;
                        r_rsp   <= '0;
                        r_blk   <= '0;
                        r_vis   <= 1'b1;
                     end else begin
                        r_rsp <= r_rsp + 1'b1;
                        if (r_blk == BLK_LAST) begin
                           r_blk <= '0;
                           r_vis <= !r_vis;
                        end else begin
                           r_blk <= r_blk + 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_speed <= '0;
                  r_vis   <= 1'b1;
               end
            endcase
         end
      end
   end

   assign xpos_out     = r_x;
   assign speed_out    = r_speed;
   assign ship_visible = r_vis;
   assign respawn_busy = (r_state == ST_DEAD) || (r_state == ST_RESPAWN);

endmodule

// File: tb/tb_ship_motion_ctl.sv
// Bench for ship_motion_ctl: a cycle model pushes the expected outputs for
// every clock into a scoreboard queue; a monitor pops and compares after each
// edge. Scenario tasks add their own fixed-value checks at key points.
module tb_ship_motion_ctl;

   localparam int TD    = 4;
   localparam int MAXS  = 3;
   localparam int ACC   = 2;
   localparam int RSPT  = 6;
   localparam int BLK   = 2;
   localparam int XRST  = 472;
   localparam int XMIN  = 80;
   localparam int XMAX  = 861;

   localparam int S_IDLE = 0;
   localparam int S_ML   = 1;
   localparam int S_MR   = 2;
   localparam int S_DEAD = 3;
   localparam int S_RSP  = 4;

   typedef struct packed {
      logic [10:0] x;
      logic [2:0]  spd;
      logic        vis;
      logic        busy;
   } obs_t;

   logic        pclk;
   logic        rst;
   logic        dead_s;
   logic        left;
   logic        right;
   logic        freeze;
   logic [10:0] xpos_out;
   logic [2:0]  speed_out;
   logic        ship_visible;
   logic        respawn_busy;

   int n_cmp = 0;
   int n_err = 0;
   obs_t sb_q[$];

   int m_st, m_x, m_spd, m_acc, m_rsp, m_blk, m_tc;
   bit m_vis;

   ship_motion_ctl #(
      .TICK_DIV      (TD),
      .MAX_SPEED     (MAXS),
      .ACCEL_TICKS   (ACC),
      .RESPAWN_TICKS (RSPT),
      .BLINK_TICKS   (BLK)
   ) dut (
      .pclk         (pclk),
      .rst          (rst),
      .dead_s       (dead_s),
      .left         (left),
      .right        (right),
      .freeze       (freeze),
      .xpos_out     (xpos_out),
      .speed_out    (speed_out),
      .ship_visible (ship_visible),
      .respawn_busy (respawn_busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Advance the reference model by one clock using the inputs now applied; push the result.
   task automatic model_step();
      bit tk;
      bit busy;
      obs_t e;
      if (rst) begin
         m_st = S_IDLE; m_x = XRST; m_spd = 0; m_acc = 0;
         m_rsp = 0; m_blk = 0; m_vis = 1'b1; m_tc = 0;
      end else if (!freeze) begin
         tk = (m_tc == TD - 1);
         m_tc = tk ? 0 : m_tc + 1;
         case (m_st)
            S_IDLE, S_ML, S_MR: begin
               if (dead_s) begin
                  m_st = S_DEAD; m_x = 0; m_spd = 0; m_vis = 1'b0;
               end else if (m_st == S_IDLE) begin
                  if (left && !right)      begin m_st = S_ML; m_spd = 1; m_acc = 0; end
                  else if (right && !left) begin m_st = S_MR; m_spd = 1; m_acc = 0; end
               end else begin
                  if (tk) begin
                     if (m_st == S_ML) m_x = (m_x - m_spd < XMIN) ? XMIN : m_x - m_spd;
                     else              m_x = (m_x + m_spd > XMAX) ? XMAX : m_x + m_spd;
                     m_acc++;
                     if (m_acc == ACC) begin
                        m_acc = 0;
                        if (m_spd < MAXS) m_spd++;
                     end
                  end
                  if ((m_st == S_ML) ? (!left || right) : (!right || left)) begin
                     m_st = S_IDLE; m_spd = 0;
                  end
               end
            end
            S_DEAD: if (tk) begin m_st = S_RSP; m_x = XRST; m_rsp = 0; m_blk = 0; end
            S_RSP: if (tk) begin
               m_rsp++;
               if (m_rsp == RSPT) begin
                  m_st = S_IDLE; m_vis = 1'b1;
               end else begin
                  m_blk++;
                  if (m_blk == BLK) begin m_blk = 0; m_vis = !m_vis; end
               end
            end
            default: m_st = S_IDLE;
         endcase
      end
      busy = (m_st == S_DEAD) || (m_st == S_RSP);
      e.x = 11'(m_x); e.spd = 3'(m_spd); e.vis = m_vis; e.busy = busy;
      sb_q.push_back(e);
   endtask

   // Drive n clocks: model first, then let the DUT take the edge; returns at a negedge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(negedge pclk);
      end
   endtask

   // Scoreboard monitor: compare every post-edge output against the queued expectation.
   always @(posedge pclk) begin
      obs_t e;
      obs_t a;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         a = {xpos_out, speed_out, ship_visible, respawn_busy};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got x=%0d spd=%0d vis=%b busy=%b, want x=%0d spd=%0d vis=%b busy=%b",
                     $time, a.x, a.spd, a.vis, a.busy, e.x, e.spd, e.vis, e.busy);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      run(2);
      n_cmp++; if (xpos_out !== 11'd472) begin n_err++; $display("FAIL reset_x: got %0d want 472", xpos_out); end
      n_cmp++; if (speed_out !== 3'd0) begin n_err++; $display("FAIL reset_speed: got %0d want 0", speed_out); end
      n_cmp++; if (ship_visible !== 1'b1) begin n_err++; $display("FAIL reset_visible: got %b want 1", ship_visible); end
      n_cmp++; if (respawn_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", respawn_busy); end
      rst = 1'b0;
   endtask

   task automatic test_ramp_right();
      int tbl[8] = '{473, 474, 476, 478, 481, 484, 487, 490};
      right = 1'b1;
      run(1);
      for (int k = 0; k < 8; k++) begin
         run(TD);
         n_cmp++;
         if (xpos_out !== 11'(tbl[k])) begin
            n_err++; $display("FAIL ramp_x[%0d]: got %0d want %0d", k, xpos_out, tbl[k]);
         end
      end
      n_cmp++; if (speed_out !== 3'd3) begin n_err++; $display("FAIL ramp_speed_cap: got %0d want 3", speed_out); end
      right = 1'b0;
      run(1);
      n_cmp++; if (speed_out !== 3'd0) begin n_err++; $display("FAIL ramp_release_speed: got %0d want 0", speed_out); end
   endtask

   task automatic test_clamp_left();
      left = 1'b1;
      run(1);
      n_cmp++; if (speed_out !== 3'd1) begin n_err++; $display("FAIL left_entry_speed: got %0d want 1", speed_out); end
      run(700);
      n_cmp++; if (xpos_out !== 11'd80) begin n_err++; $display("FAIL left_clamp_x: got %0d want 80", xpos_out); end
      run(12);
      n_cmp++; if (xpos_out !== 11'd80) begin n_err++; $display("FAIL left_clamp_hold: got %0d want 80", xpos_out); end
      left = 1'b0;
      run(1);
      n_cmp++; if (speed_out !== 3'd0) begin n_err++; $display("FAIL left_release_speed: got %0d want 0", speed_out); end
   endtask

   task automatic test_clamp_right();
      right = 1'b1;
      run(1200);
      n_cmp++; if (xpos_out !== 11'd861) begin n_err++; $display("FAIL right_clamp_x: got %0d want 861", xpos_out); end
      right = 1'b0;
      run(1);
   endtask

   task automatic test_both_keys();
      left = 1'b1; right = 1'b1;
      run(12);
      n_cmp++; if (xpos_out !== 11'd861) begin n_err++; $display("FAIL both_x: got %0d want 861", xpos_out); end
      n_cmp++; if (speed_out !== 3'd0) begin n_err++; $display("FAIL both_speed: got %0d want 0", speed_out); end
      left = 1'b0; right = 1'b0;
      run(1);
   endtask

   task automatic test_back_to_back();
      left = 1'b1;
      run(9);
      left = 1'b0; right = 1'b1;
      run(1);
      n_cmp++; if (speed_out !== 3'd0) begin n_err++; $display("FAIL reversal_idle_speed: got %0d want 0", speed_out); end
      run(1);
      n_cmp++; if (speed_out !== 3'd1) begin n_err++; $display("FAIL reversal_new_speed: got %0d want 1", speed_out); end
      run(8);
      right = 1'b0;
      run(1);
   endtask

   task automatic test_freeze();
      int snap_x;
      int snap_spd;
      left = 1'b1;
      run(7);
      freeze = 1'b1;
      snap_x = m_x; snap_spd = m_spd;
      run(20);
      n_cmp++; if (xpos_out !== 11'(snap_x)) begin n_err++; $display("FAIL freeze_x: got %0d want %0d", xpos_out, snap_x); end
      n_cmp++; if (speed_out !== 3'(snap_spd)) begin n_err++; $display("FAIL freeze_speed: got %0d want %0d", speed_out, snap_spd); end
      freeze = 1'b0;
      run(9);
      left = 1'b0;
      run(1);
   endtask

   task automatic test_death_respawn();
      int k;
      int vis_tbl[5] = '{0, 1, 1, 0, 0};
      right = 1'b1;
      run(6);
      dead_s = 1'b1;
      run(1);
      dead_s = 1'b0; right = 1'b0; left = 1'b1;
      n_cmp++; if (xpos_out !== 11'd0) begin n_err++; $display("FAIL dead_x: got %0d want 0", xpos_out); end
      n_cmp++; if (ship_visible !== 1'b0) begin n_err++; $display("FAIL dead_visible: got %b want 0", ship_visible); end
      n_cmp++; if (respawn_busy !== 1'b1) begin n_err++; $display("FAIL dead_busy: got %b want 1", respawn_busy); end
      k = 0;
      while (xpos_out !== 11'd472 && k < TD + 2) begin
         run(1);
         k++;
      end
      n_cmp++; if (xpos_out !== 11'd472) begin n_err++; $display("FAIL respawn_entry_x: got %0d want 472 within %0d cycles", xpos_out, TD + 2); end
      for (int w = 0; w < 5; w++) begin
         run(TD);
         if (w == 0) left = 1'b0;
         n_cmp++;
         if (ship_visible !== 1'(vis_tbl[w]) || respawn_busy !== 1'b1) begin
            n_err++; $display("FAIL respawn_blink[%0d]: got vis=%b busy=%b want vis=%0d busy=1", w, ship_visible, respawn_busy, vis_tbl[w]);
         end
      end
      run(TD - 1);
      n_cmp++; if (respawn_busy !== 1'b1) begin n_err++; $display("FAIL respawn_not_early: got busy=%b want 1", respawn_busy); end
      run(1);
      n_cmp++;
      if (respawn_busy !== 1'b0 || ship_visible !== 1'b1 || xpos_out !== 11'd472) begin
         n_err++; $display("FAIL respawn_exit: got busy=%b vis=%b x=%0d want busy=0 vis=1 x=472", respawn_busy, ship_visible, xpos_out);
      end
   endtask

   task automatic test_rst_in_respawn();
      dead_s = 1'b1;
      run(1);
      dead_s = 1'b0;
      run(10);
      n_cmp++; if (respawn_busy !== 1'b1) begin n_err++; $display("FAIL pre_rst_busy: got %b want 1", respawn_busy); end
      rst = 1'b1; freeze = 1'b1;
      run(1);
      n_cmp++;
      if (xpos_out !== 11'd472 || ship_visible !== 1'b1 || respawn_busy !== 1'b0 || speed_out !== 3'd0) begin
         n_err++; $display("FAIL rst_in_respawn: got x=%0d vis=%b busy=%b spd=%0d want x=472 vis=1 busy=0 spd=0",
                           xpos_out, ship_visible, respawn_busy, speed_out);
      end
      rst = 1'b0; freeze = 1'b0;
      run(TD + 1);
      n_cmp++; if (respawn_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got busy=%b want 0", respawn_busy); end
   endtask

   initial begin
      rst = 1'b1; dead_s = 1'b0; left = 1'b0; right = 1'b0; freeze = 1'b0;
      @(negedge pclk);
      test_reset();
      test_ramp_right();
      test_clamp_left();
      test_clamp_right();
      test_both_keys();
      test_back_to_back();
      test_freeze();
      test_death_respawn();
      test_rst_in_respawn();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
